mmio_timer: RTL and testbench

MMIO_TIMER -- requirements
Module: mmio_timer

---
 rtl/mmio_timer.sv | 155 +++++++++++++++
 tb/tb_mmio_timer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with a prescaler, auto-reload and a level IRQ.
// Ports: clk, reset (async active-low), mem_cmd/mem_addr/write_data in; rd_data, rd_en, irq, running out.
module mmio_timer #(
  parameter logic [8:0]  BASE     = 9'h180,
  parameter logic [15:0] PRESCALE = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] rd_data,
  output logic        rd_en,
  output logic        irq,
  output logic        running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]  CMD_WR = 2'b01;
  localparam logic [1:0]  CMD_RD = 2'b10;
  localparam logic [15:0] PS_MAX = PRESCALE - 16'd1;

  state_t      state;
  state_t      state_n;
  logic [2:0]  ctrl;
  logic [15:0] load;
  logic [15:0] count;
  logic [15:0] count_n;
  logic [15:0] presc;
  logic [15:0] presc_n;
  logic        exp_flag;
  logic        exp_n;
  logic [15:0] rdata;

  logic       hit;
  logic [1:0] offset;
  logic       is_wr;
  logic       is_rd;
  logic       wr_ctrl;
  logic       wr_load;
  logic       wr_stat;
  logic       tick;
  logic       expire;
  logic       stop;

  assign hit    = (mem_addr[8:2] == BASE[8:2]);
  assign offset = mem_addr[1:0];
  assign is_wr  = (mem_cmd == CMD_WR) && hit;
  assign is_rd  = (mem_cmd == CMD_RD) && hit;

  assign wr_ctrl = is_wr && (offset == 2'd0);
  assign wr_load = is_wr && (offset == 2'd1);
  assign wr_stat = is_wr && (offset == 2'd3);

  assign tick   = (state == RUN) && (presc == PS_MAX);
  assign expire = tick && (count == 16'd0);
  // Disabling in RUN takes priority over a tick on the same edge.
  assign stop   = (state == RUN) && wr_ctrl && !write_data[0];

  assign rd_en   = is_rd;
  assign irq     = exp_flag && ctrl[2];
  assign running = (state == RUN);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (wr_ctrl && write_data[0])
          state_n = RUN;
      end
      RUN: begin
        if (stop)
          state_n = IDLE;
        else if (expire && !ctrl[1])
          state_n = DONE;
      end
      DONE: begin
        if (wr_ctrl && !write_data[0])
          state_n = IDLE;
        else if (wr_load && ctrl[0])
          state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  // Prescaler only advances while staying in RUN;
  // any entry to or exit from RUN restarts it at zero.
  always_comb begin
    presc_n = 16'd0;
    if (state == RUN && state_n == RUN)
      presc_n = tick ? 16'd0 : presc + 16'd1;
  end

  always_comb begin
    count_n = count;
    if (wr_load && state != RUN) begin
      count_n = write_data;
    end else if (tick && !stop) begin
      if (count != 16'd0)
        count_n = count - 16'd1;
      else if (ctrl[1])
        count_n = load;
    end
  end

  // Expiry is applied after the clear so it wins a same-edge collision.
  always_comb begin
    exp_n = exp_flag;
    if (wr_stat && write_data[0])
      exp_n = 1'b0;
    if (expire && !stop)
      exp_n = 1'b1;
  end

  always_comb begin
    rdata = 16'h0000;
    unique case (1'b1)
      offset == 2'd0: rdata = {13'd0, ctrl};
      offset == 2'd1: rdata = load;
      offset == 2'd2: rdata = count;
      offset == 2'd3: rdata = {15'd0, exp_flag};
      default:        rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ctrl     <= 3'd0;
      load     <= 16'd0;
      count    <= 16'd0;
      presc    <= 16'd0;
      exp_flag <= 1'b0;
      rd_data  <= 16'h0000;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      count    <= count_n;
      exp_flag <= exp_n;
      if (wr_ctrl)
        ctrl <= write_data[2:0];
      if (wr_load)
        load <= write_data;
      if (is_rd)
        rd_data <= rdata;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer (PRESCALE=4, BASE=9'h180).
// Tasks start and end just after a falling edge; each bus op spans one rising edge.
module tb_mmio_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] rd_data;
  logic        rd_en;
  logic        irq;
  logic        running;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] A_CTRL  = 9'h180;
  localparam logic [8:0] A_LOAD  = 9'h181;
  localparam logic [8:0] A_COUNT = 9'h182;
  localparam logic [8:0] A_STAT  = 9'h183;

  mmio_timer #(
    .BASE(9'h180),
    .PRESCALE(16'd4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_cmd(mem_cmd),
    .mem_addr(mem_addr),
    .write_data(write_data),
    .rd_data(rd_data),
    .rd_en(rd_en),
    .irq(irq),
    .running(running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [15:0] d);
    mem_cmd = 2'b01;
    mem_addr = a;
    write_data = d;
    @(negedge clk);
    mem_cmd = 2'b00;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [15:0] v);
    mem_cmd = 2'b10;
    mem_addr = a;
    @(negedge clk);
    v = rd_data;
    mem_cmd = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_cmd = 2'b00;
    mem_addr = 9'h000;
    write_data = 16'h0000;
    idle(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL reset_running: got %b want 0", running);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b want 0", irq);
    end
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data);
    end
    bus_read(A_CTRL, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++; $display("FAIL reset_ctrl: got %h want 0000", v);
    end
  endtask

  task automatic test_oneshot();
    logic [15:0] v;
    logic [15:0] want;
    do_reset();
    bus_write(A_LOAD, 16'd3);
    bus_write(A_CTRL, 16'h0005);
    for (int k = 1; k <= 16; k++) begin
      bus_read(A_COUNT, v);
      want = 16'(3 - (k - 1) / 4);
      checks++;
      if (v !== want) begin
        errors++; $display("FAIL oneshot_count k=%0d: got %h want %h", k, v, want);
      end
      checks++;
      if (irq !== 1'(k == 16)) begin
        errors++; $display("FAIL oneshot_irq k=%0d: got %b want %b", k, irq, k == 16);
      end
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL oneshot_done_running: got %b want 0", running);
    end
    bus_read(A_STAT, v);
    checks++;
    if (v !== 16'h0001) begin
      errors++; $display("FAIL oneshot_status: got %h want 0001", v);
    end
    bus_write(A_LOAD, 16'd1);
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL done_reload_running: got %b want 1", running);
    end
    bus_read(A_COUNT, v);
    checks++;
    if (v !== 16'd1) begin
      errors++; $display("FAIL done_reload_count: got %h want 0001", v);
    end
  endtask

  task automatic test_auto();
    logic [15:0] v;
    logic [15:0] want;
    do_reset();
    bus_write(A_LOAD, 16'd1);
    bus_write(A_CTRL, 16'h0003);
    for (int k = 1; k <= 8; k++) begin
      bus_read(A_COUNT, v);
      want = (k <= 4) ? 16'd1 : 16'd0;
      checks++;
      if (v !== want) begin
        errors++; $display("FAIL auto_count k=%0d: got %h want %h", k, v, want);
      end
    end
    checks++;
    if (running !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL auto_run_irq: got run=%b irq=%b want run=1 irq=0", running, irq);
    end
    bus_read(A_STAT, v);
    checks++;
    if (v !== 16'h0001) begin
      errors++; $display("FAIL auto_exp_set: got %h want 0001", v);
    end
    bus_write(A_STAT, 16'h0001);
    bus_read(A_STAT, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++; $display("FAIL auto_w1c: got %h want 0000", v);
    end
    for (int k = 12; k <= 17; k++) begin
      bus_read(A_STAT, v);
      want = (k == 17) ? 16'h0001 : 16'h0000;
      checks++;
      if (v !== want) begin
        errors++; $display("FAIL auto_second_exp k=%0d: got %h want %h", k, v, want);
      end
    end
    bus_read(A_COUNT, v);
    checks++;
    if (v !== 16'd1) begin
      errors++; $display("FAIL auto_reload: got %h want 0001", v);
    end
  endtask

  task automatic test_read_bus();
    do_reset();
    bus_write(A_LOAD, 16'h00A5);
    mem_cmd = 2'b10;
    mem_addr = A_COUNT;
    #1;
    checks++;
    if (rd_en !== 1'b1) begin
      errors++; $display("FAIL read_en_cycle1: got %b want 1", rd_en);
    end
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || rd_data !== 16'h00A5) begin
      errors++; $display("FAIL read_cycle2: got en=%b data=%h want en=1 data=00a5", rd_en, rd_data);
    end
    @(negedge clk);
    mem_addr = 9'h100;
    #1;
    checks++;
    if (rd_en !== 1'b0) begin
      errors++; $display("FAIL read_miss100_en: got %b want 0", rd_en);
    end
    @(negedge clk);
    mem_addr = 9'h140;
    #1;
    checks++;
    if (rd_en !== 1'b0) begin
      errors++; $display("FAIL read_miss140_en: got %b want 0", rd_en);
    end
    @(negedge clk);
    mem_cmd = 2'b00;
    checks++;
    if (rd_data !== 16'h00A5) begin
      errors++; $display("FAIL read_miss_hold: got %h want 00a5", rd_data);
    end
  endtask

  task automatic test_w1c_collision();
    logic [15:0] v;
    do_reset();
    bus_write(A_LOAD, 16'd0);
    bus_write(A_CTRL, 16'h0005);
    idle(3);
    checks++;
    if (irq !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL zero_load_pre: got irq=%b run=%b want 0/1", irq, running);
    end
    bus_write(A_STAT, 16'h0001);
    checks++;
    if (irq !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL collision_post: got irq=%b run=%b want 1/0", irq, running);
    end
    bus_read(A_STAT, v);
    checks++;
    if (v !== 16'h0001) begin
      errors++; $display("FAIL collision_exp: got %h want 0001", v);
    end
    bus_write(A_STAT, 16'h0001);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL w1c_irq_clear: got %b want 0", irq);
    end
  endtask

  task automatic test_stop_restart();
    logic [15:0] v;
    do_reset();
    bus_write(A_LOAD, 16'd3);
    bus_write(A_CTRL, 16'h0001);
    idle(5);
    bus_write(A_CTRL, 16'h0000);
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL stop_running: got %b want 0", running);
    end
    idle(8);
    bus_read(A_COUNT, v);
    checks++;
    if (v !== 16'd2) begin
      errors++; $display("FAIL stop_hold: got %h want 0002", v);
    end
    bus_write(A_CTRL, 16'h0001);
    idle(3);
    bus_read(A_COUNT, v);
    checks++;
    if (v !== 16'd2) begin
      errors++; $display("FAIL restart_pre_tick: got %h want 0002", v);
    end
    bus_read(A_COUNT, v);
    checks++;
    if (v !== 16'd1) begin
      errors++; $display("FAIL restart_tick: got %h want 0001", v);
    end
  endtask

  task automatic test_run_rewrite();
    do_reset();
    bus_write(A_LOAD, 16'd2);
    bus_write(A_CTRL, 16'h0001);
    idle(1);
    bus_write(A_CTRL, 16'h0005);
    idle(9);
    checks++;
    if (irq !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL rewrite_pre: got irq=%b run=%b want 0/1", irq, running);
    end
    idle(1);
    checks++;
    if (irq !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL rewrite_expire: got irq=%b run=%b want 1/0", irq, running);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] v;
    do_reset();
    bus_write(A_LOAD, 16'd5);
    bus_write(A_CTRL, 16'h0005);
    bus_read(A_COUNT, v);
    checks++;
    if (v !== 16'd5) begin
      errors++; $display("FAIL midrun_count: got %h want 0005", v);
    end
    idle(1);
    reset = 1'b0;
    mem_cmd = 2'b10;
    mem_addr = A_COUNT;
    #1;
    checks++;
    if (running !== 1'b0 || irq !== 1'b0 || rd_data !== 16'h0000) begin
      errors++; $display("FAIL midrun_reset_now: got run=%b irq=%b data=%h want 0/0/0000", running, irq, rd_data);
    end
    checks++;
    if (rd_en !== 1'b1) begin
      errors++; $display("FAIL reset_rd_en: got %b want 1", rd_en);
    end
    @(negedge clk);
    mem_cmd = 2'b00;
    reset = 1'b1;
    bus_read(A_CTRL, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++; $display("FAIL post_reset_ctrl: got %h want 0000", v);
    end
    bus_read(A_LOAD, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++; $display("FAIL post_reset_load: got %h want 0000", v);
    end
    bus_read(A_STAT, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++; $display("FAIL post_reset_status: got %h want 0000", v);
    end
    idle(10);
    bus_read(A_COUNT, v);
    checks++;
    if (v !== 16'h0000 || running !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got count=%h run=%b want 0000/0", v, running);
    end
  endtask

  task automatic test_ignored_writes();
    logic [15:0] v;
    do_reset();
    bus_write(A_LOAD, 16'd7);
    bus_write(A_COUNT, 16'hFFFF);
    bus_read(A_COUNT, v);
    checks++;
    if (v !== 16'd7) begin
      errors++; $display("FAIL count_write_ignored: got %h want 0007", v);
    end
    mem_cmd = 2'b11;
    mem_addr = A_LOAD;
    write_data = 16'h1234;
    #1;
    checks++;
    if (rd_en !== 1'b0) begin
      errors++; $display("FAIL cmd11_rd_en: got %b want 0", rd_en);
    end
    @(negedge clk);
    mem_addr = A_CTRL;
    write_data = 16'h0007;
    @(negedge clk);
    mem_cmd = 2'b00;
    bus_write(9'h101, 16'h5555);
    bus_read(A_LOAD, v);
    checks++;
    if (v !== 16'd7) begin
      errors++; $display("FAIL cmd11_load: got %h want 0007", v);
    end
    bus_read(A_CTRL, v);
    checks++;
    if (v !== 16'h0000 || running !== 1'b0) begin
      errors++; $display("FAIL cmd11_ctrl: got %h run=%b want 0000/0", v, running);
    end
  endtask

  initial begin
    reset = 1'b0;
    mem_cmd = 2'b00;
    mem_addr = 9'h000;
    write_data = 16'h0000;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_auto();
    test_read_bus();
    test_w1c_collision();
    test_stop_restart();
    test_run_rewrite();
    test_reset_mid_run();
    test_ignored_writes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
